pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Sequences every control-flow redirect into the fetch PC register. Collects exception, flush, jump and return requests from the pipeline, resolves their priority and holds the winner while fetch is stalled. It then presents exactly one redirect to the PC register and squashes the wrong-path fetch slots for a programmable number of cycles. Sits between EX/MEM/CP0 redirect sources and the PC register, and drives its jump-flag/jump-address inputs.

## Interface
Parameters:
- ADDR_W, 32, instruction address width
- KILL_CYCLES, 2, squash cycles after a redirect is consumed; legal range 0–7

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- stall  input  6  pipeline stall vector; only bit 0 (fetch stall) is used
- exp_fl  input  1  exception redirect request
- exp_addr  input  ADDR_W  exception handler address; also the flush target
- flush  input  1  pipeline flush request; target is exp_addr
- jmp_fl  input  1  jump/branch redirect request
- jmp_addr  input  ADDR_W  jump target
- ret_fl  input  1  return redirect request
- ret_addr  input  ADDR_W  return target
- redir_valid  output  1  redirect pending toward PC register
- redir_addr  output  ADDR_W  redirect target
- redir_src  output  2  winning source: 0 ret, 1 jmp, 2 flush, 3 exp
- squash  output  1  invalidate IF/ID contents

## Operation
- Priority, high to low: exp > flush > jmp > ret. Same-cycle requests are resolved combinationally to a single candidate (cand_src, cand_addr).
- The pending register holds redir_addr and redir_src. All outputs are registered.
- FSM states:
  - IDLE: redir_valid=0, squash=0. Any request → PEND, candidate captured.
  - PEND: redir_valid=1, squash=1. Held while stall[0]=1.
    - New candidate with priority ≥ pending src overwrites the pending register (equal priority: newer wins).
    - Lower-priority candidate is dropped.
    - Consumed at a rising edge with stall[0]=0.
    - On consumption: if a candidate is present that edge → stay PEND with the new candidate; else KILL_CYCLES>0 → KILL with counter loaded to KILL_CYCLES; else → IDLE.
  - KILL: redir_valid=0, squash=1.
    - Counter decrements only when stall[0]=0.
    - Counter reaching 0 → IDLE.
    - Any candidate → PEND; counter is discarded.
- Kill counter is 3 bits.
- redir_addr is passed through at ADDR_W bits with no arithmetic.
- Reset at any time discards the pending redirect and the kill count.

## Timing
- Reset values: redir_valid=0, redir_addr=0, redir_src=0, squash=0, state IDLE, kill counter 0.
- Request in cycle N (state IDLE) → redir_valid=1 in cycle N+1.
- PC register loads redir_addr at the first edge where redir_valid=1 and stall[0]=0.
- redir_valid drops in the following cycle unless a new candidate was captured at that edge.
- squash is high from N+1 through KILL_CYCLES non-stalled cycles after consumption.
- With stall[0] held high, redir_valid/redir_addr stay stable except for higher-or-equal priority overwrite.
- A request arriving at the same edge as consumption is never lost.

## Configuration
- PC_REDIR_CNT_EN defined: adds output redir_cnt [15:0].
  - Increments by 1 at every consumption edge; wraps 16'hFFFF → 0.
  - Reset value 0.
- Macro undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset release, no requests → redir_valid=0, squash=0, redir_addr=0 for 10 cycles.
- jmp_fl=1, jmp_addr=32'h0000_0100 for 1 cycle, stall=0, KILL_CYCLES=2 → next cycle redir_valid=1, redir_src=1, addr 0x100. Then 1 cycle later redir_valid=0; squash stays high 2 further cycles, then IDLE.
- stall[0]=1 for 5 cycles; ret (0x200) in cycle 1, jmp (0x300) in cycle 2, ret (0x400) in cycle 3 → pending src=1, addr 0x300 held until stall drops, then consumed once.
- exp_fl and jmp_fl in the same cycle (exp_addr=32'hA000_0180, jmp 0x500) → redir_src=3, redir_addr 0xA0000180; jmp dropped.
- New jmp (0x600) arriving exactly at the consumption edge of a pending ret (0x700) → ret consumed, then redir_valid stays 1 with addr 0x600, src 1.
- rst asserted low while in PEND with stall[0]=1 → all outputs 0 immediately (asynchronous); after release state is IDLE. With PC_REDIR_CNT_EN, redir_cnt=0.

Source files
------------

// File: rtl/pc_redirect_ctrl_if.sv
// Redirect bus between the pipeline redirect sources, the PC register and pc_redirect_ctrl.
// Optional PC_REDIR_CNT_EN adds the redir_cnt consumption counter.
interface pc_redirect_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [5:0]        stall;
  logic              exp_fl;
  logic [ADDR_W-1:0] exp_addr;
  logic              flush;
  logic              jmp_fl;
  logic [ADDR_W-1:0] jmp_addr;
  logic              ret_fl;
  logic [ADDR_W-1:0] ret_addr;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_addr;
  logic [1:0]        redir_src;
  logic              squash;
`ifdef PC_REDIR_CNT_EN
  logic [15:0]       redir_cnt;
`endif

  modport master (
    output stall, exp_fl, exp_addr, flush, jmp_fl, jmp_addr, ret_fl, ret_addr,
`ifdef PC_REDIR_CNT_EN
    input  redir_cnt,
`endif
    input  redir_valid, redir_addr, redir_src, squash
  );

  modport slave (
    input  stall, exp_fl, exp_addr, flush, jmp_fl, jmp_addr, ret_fl, ret_addr,
`ifdef PC_REDIR_CNT_EN
    output redir_cnt,
`endif
    output redir_valid, redir_addr, redir_src, squash
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Prioritises exception/flush/jump/return redirects, holds the winner across fetch stalls and
// squashes wrong-path fetch slots afterwards. Optional PC_REDIR_CNT_EN adds redir_cnt.
module pc_redirect_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int KILL_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  pc_redirect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_KILL = 2'd2
  } state_e;

  localparam logic [1:0] SRC_RET = 2'd0;
  localparam logic [1:0] SRC_JMP = 2'd1;
  localparam logic [1:0] SRC_FLS = 2'd2;
  localparam logic [1:0] SRC_EXP = 2'd3;
  localparam logic [2:0] KILL_INIT = 3'(KILL_CYCLES);

  state_e            state_r, state_nx_s;
  logic [2:0]        kill_cnt_r, kill_cnt_nx_s;
  logic              cand_valid_s;
  logic [1:0]        cand_src_s;
  logic [ADDR_W-1:0] cand_addr_s;
  logic              load_s;
  logic              consume_s;
  logic              redir_valid_r;
  logic              squash_r;
  logic [1:0]        redir_src_r;
  logic [ADDR_W-1:0] redir_addr_r;

  // Fixed-priority pick of this cycle's request; flush shares the exception target.
  always_comb begin
    cand_valid_s = bus.exp_fl | bus.flush | bus.jmp_fl | bus.ret_fl;
    cand_src_s   = SRC_RET;
    cand_addr_s  = bus.ret_addr;
    if (bus.exp_fl) begin
      cand_src_s  = SRC_EXP;
      cand_addr_s = bus.exp_addr;
    end else if (bus.flush) begin
      cand_src_s  = SRC_FLS;
      cand_addr_s = bus.exp_addr;
    end else if (bus.jmp_fl) begin
      cand_src_s  = SRC_JMP;
      cand_addr_s = bus.jmp_addr;
    end else begin
      cand_src_s  = SRC_RET;
      cand_addr_s = bus.ret_addr;
    end
  end

  // Next-state logic; a request landing on the consumption edge is captured, never lost.
  always_comb begin
    state_nx_s    = state_r;
    kill_cnt_nx_s = kill_cnt_r;
    load_s        = 1'b0;
    consume_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cand_valid_s) begin
          state_nx_s = ST_PEND;
          load_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (!bus.stall[0]) begin
          consume_s = 1'b1;
          if (cand_valid_s) begin
            state_nx_s = ST_PEND;
            load_s     = 1'b1;
          end else if (KILL_INIT != 3'd0) begin
            state_nx_s    = ST_KILL;
            kill_cnt_nx_s = KILL_INIT;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else if (cand_valid_s && (cand_src_s >= redir_src_r)) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_KILL: begin
        if (cand_valid_s) begin
          state_nx_s    = ST_PEND;
          kill_cnt_nx_s = 3'd0;
          load_s        = 1'b1;
        end else if (!bus.stall[0]) begin
          if (kill_cnt_r <= 3'd1) begin
            state_nx_s    = ST_IDLE;
            kill_cnt_nx_s = 3'd0;
          end else begin
            kill_cnt_nx_s = kill_cnt_r - 3'd1;
          end
        end else begin
          state_nx_s = ST_KILL;
        end
      end
      default: begin
        state_nx_s    = ST_IDLE;
        kill_cnt_nx_s = 3'd0;
      end
    endcase
  end

  // State, kill counter, pending redirect and registered flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      kill_cnt_r    <= 3'd0;
      redir_valid_r <= 1'b0;
      squash_r      <= 1'b0;
      redir_src_r   <= 2'd0;
      redir_addr_r  <= '0;
    end else begin
      state_r       <= state_nx_s;
      kill_cnt_r    <= kill_cnt_nx_s;
      redir_valid_r <= (state_nx_s == ST_PEND);
      squash_r      <= (state_nx_s != ST_IDLE);
      if (load_s) begin
        redir_src_r  <= cand_src_s;
        redir_addr_r <= cand_addr_s;
      end
    end
  end

`ifdef PC_REDIR_CNT_EN
  logic [15:0] redir_cnt_r;

  // Counts consumed redirects, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redir_cnt_r <= 16'd0;
    end else if (consume_s) begin
      redir_cnt_r <= redir_cnt_r + 16'd1;
    end
  end

  assign bus.redir_cnt = redir_cnt_r;
`endif

  assign bus.redir_valid = redir_valid_r;
  assign bus.redir_addr  = redir_addr_r;
  assign bus.redir_src   = redir_src_r;
  assign bus.squash      = squash_r;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl (ADDR_W=32, KILL_CYCLES=2).
module tb_pc_redirect_ctrl;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  pc_redirect_ctrl_if #(.ADDR_W(32)) bus ();

  pc_redirect_ctrl #(.ADDR_W(32), .KILL_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.exp_fl   = 1'b0;
    bus.flush    = 1'b0;
    bus.jmp_fl   = 1'b0;
    bus.ret_fl   = 1'b0;
    bus.exp_addr = 32'h0;
    bus.jmp_addr = 32'h0;
    bus.ret_addr = 32'h0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL reset_valid cyc %0d: got %b want 0", i, bus.redir_valid); end
      tests++; if (bus.squash !== 1'b0) begin fails++; $display("FAIL reset_squash cyc %0d: got %b want 0", i, bus.squash); end
      tests++; if (bus.redir_addr !== 32'h0) begin fails++; $display("FAIL reset_addr cyc %0d: got %h want 0", i, bus.redir_addr); end
    end
    tests++; if (bus.redir_src !== 2'd0) begin fails++; $display("FAIL reset_src: got %0d want 0", bus.redir_src); end
`ifdef PC_REDIR_CNT_EN
    tests++; if (bus.redir_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", bus.redir_cnt); end
`endif
  endtask

  task automatic test_jump();
    bus.jmp_fl = 1'b1; bus.jmp_addr = 32'h0000_0100;
    tick();
    clear_reqs();
    tests++; if (bus.redir_valid !== 1'b1) begin fails++; $display("FAIL jump_valid: got %b want 1", bus.redir_valid); end
    tests++; if (bus.redir_src !== 2'd1) begin fails++; $display("FAIL jump_src: got %0d want 1", bus.redir_src); end
    tests++; if (bus.redir_addr !== 32'h0000_0100) begin fails++; $display("FAIL jump_addr: got %h want 00000100", bus.redir_addr); end
    tests++; if (bus.squash !== 1'b1) begin fails++; $display("FAIL jump_squash0: got %b want 1", bus.squash); end
    tick();
    tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL jump_consumed: got %b want 0", bus.redir_valid); end
    tests++; if (bus.squash !== 1'b1) begin fails++; $display("FAIL jump_squash1: got %b want 1", bus.squash); end
`ifdef PC_REDIR_CNT_EN
    tests++; if (bus.redir_cnt !== 16'd1) begin fails++; $display("FAIL jump_cnt: got %0d want 1", bus.redir_cnt); end
`endif
    tick();
    tests++; if (bus.squash !== 1'b1) begin fails++; $display("FAIL jump_squash2: got %b want 1", bus.squash); end
    tick();
    tests++; if (bus.squash !== 1'b0) begin fails++; $display("FAIL jump_idle_squash: got %b want 0", bus.squash); end
    tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL jump_idle_valid: got %b want 0", bus.redir_valid); end
  endtask

  task automatic test_stall_priority();
    bus.stall = 6'b000001;
    bus.ret_fl = 1'b1; bus.ret_addr = 32'h0000_0200;
    tick();
    clear_reqs();
    tests++; if (bus.redir_addr !== 32'h0000_0200) begin fails++; $display("FAIL stall_first_addr: got %h want 00000200", bus.redir_addr); end
    bus.jmp_fl = 1'b1; bus.jmp_addr = 32'h0000_0300;
    tick();
    clear_reqs();
    bus.ret_fl = 1'b1; bus.ret_addr = 32'h0000_0400;
    tick();
    clear_reqs();
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.redir_valid !== 1'b1) begin fails++; $display("FAIL stall_hold_valid cyc %0d: got %b want 1", i, bus.redir_valid); end
      tests++; if (bus.redir_addr !== 32'h0000_0300) begin fails++; $display("FAIL stall_hold_addr cyc %0d: got %h want 00000300", i, bus.redir_addr); end
      tests++; if (bus.redir_src !== 2'd1) begin fails++; $display("FAIL stall_hold_src cyc %0d: got %0d want 1", i, bus.redir_src); end
      if (i < 2) tick();
    end
    bus.stall = 6'b000000;
    tick();
    tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL stall_consumed: got %b want 0", bus.redir_valid); end
    tick();
    tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL stall_once: got %b want 0", bus.redir_valid); end
    tick();
    tests++; if (bus.squash !== 1'b0) begin fails++; $display("FAIL stall_idle_squash: got %b want 0", bus.squash); end
  endtask

  task automatic test_same_cycle();
    bus.exp_fl = 1'b1; bus.exp_addr = 32'hA000_0180;
    bus.jmp_fl = 1'b1; bus.jmp_addr = 32'h0000_0500;
    tick();
    clear_reqs();
    tests++; if (bus.redir_src !== 2'd3) begin fails++; $display("FAIL same_src: got %0d want 3", bus.redir_src); end
    tests++; if (bus.redir_addr !== 32'hA000_0180) begin fails++; $display("FAIL same_addr: got %h want a0000180", bus.redir_addr); end
    tick();
    tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL same_jmp_dropped: got %b want 0", bus.redir_valid); end
    tick();
    tick();
    tests++; if (bus.squash !== 1'b0) begin fails++; $display("FAIL same_idle_squash: got %b want 0", bus.squash); end
  endtask

  task automatic test_back_to_back();
    bus.stall = 6'b000001;
    bus.ret_fl = 1'b1; bus.ret_addr = 32'h0000_0700;
    tick();
    clear_reqs();
    tests++; if (bus.redir_src !== 2'd0) begin fails++; $display("FAIL b2b_ret_src: got %0d want 0", bus.redir_src); end
    bus.stall = 6'b000000;
    bus.jmp_fl = 1'b1; bus.jmp_addr = 32'h0000_0600;
    tick();
    clear_reqs();
    tests++; if (bus.redir_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b want 1", bus.redir_valid); end
    tests++; if (bus.redir_addr !== 32'h0000_0600) begin fails++; $display("FAIL b2b_addr: got %h want 00000600", bus.redir_addr); end
    tests++; if (bus.redir_src !== 2'd1) begin fails++; $display("FAIL b2b_src: got %0d want 1", bus.redir_src); end
    tick();
    tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL b2b_consumed: got %b want 0", bus.redir_valid); end
    tick();
    tick();
    tests++; if (bus.squash !== 1'b0) begin fails++; $display("FAIL b2b_idle_squash: got %b want 0", bus.squash); end
  endtask

  task automatic test_flush_equal();
    bus.stall = 6'b000001;
    bus.flush = 1'b1; bus.exp_addr = 32'h0000_1000;
    tick();
    clear_reqs();
    tests++; if (bus.redir_src !== 2'd2) begin fails++; $display("FAIL flush_src: got %0d want 2", bus.redir_src); end
    tests++; if (bus.redir_addr !== 32'h0000_1000) begin fails++; $display("FAIL flush_addr: got %h want 00001000", bus.redir_addr); end
    bus.jmp_fl = 1'b1; bus.jmp_addr = 32'h0000_1100;
    tick();
    clear_reqs();
    tests++; if (bus.redir_addr !== 32'h0000_1000) begin fails++; $display("FAIL flush_low_drop: got %h want 00001000", bus.redir_addr); end
    bus.flush = 1'b1; bus.exp_addr = 32'h0000_1200;
    tick();
    clear_reqs();
    tests++; if (bus.redir_addr !== 32'h0000_1200) begin fails++; $display("FAIL flush_equal_newer: got %h want 00001200", bus.redir_addr); end
    bus.exp_fl = 1'b1; bus.exp_addr = 32'h0000_1300;
    tick();
    clear_reqs();
    tests++; if (bus.redir_src !== 2'd3) begin fails++; $display("FAIL flush_exp_over: got %0d want 3", bus.redir_src); end
    tests++; if (bus.redir_addr !== 32'h0000_1300) begin fails++; $display("FAIL flush_exp_addr: got %h want 00001300", bus.redir_addr); end
    bus.stall = 6'b000000;
    tick();
    tick();
    tick();
    tests++; if (bus.squash !== 1'b0) begin fails++; $display("FAIL flush_idle_squash: got %b want 0", bus.squash); end
  endtask

  task automatic test_kill();
    bus.jmp_fl = 1'b1; bus.jmp_addr = 32'h0000_0800;
    tick();
    clear_reqs();
    tick();
    bus.ret_fl = 1'b1; bus.ret_addr = 32'h0000_0900;
    tick();
    clear_reqs();
    tests++; if (bus.redir_valid !== 1'b1) begin fails++; $display("FAIL kill_interrupt_valid: got %b want 1", bus.redir_valid); end
    tests++; if (bus.redir_addr !== 32'h0000_0900) begin fails++; $display("FAIL kill_interrupt_addr: got %h want 00000900", bus.redir_addr); end
    tick();
    bus.stall = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.squash !== 1'b1) begin fails++; $display("FAIL kill_stall_hold cyc %0d: got %b want 1", i, bus.squash); end
    end
    bus.stall = 6'b000000;
    tick();
    tests++; if (bus.squash !== 1'b1) begin fails++; $display("FAIL kill_last: got %b want 1", bus.squash); end
    tick();
    tests++; if (bus.squash !== 1'b0) begin fails++; $display("FAIL kill_done: got %b want 0", bus.squash); end
  endtask

  task automatic test_async_reset();
    bus.stall = 6'b000001;
    bus.ret_fl = 1'b1; bus.ret_addr = 32'h0000_0200;
    tick();
    clear_reqs();
    tests++; if (bus.redir_valid !== 1'b1) begin fails++; $display("FAIL areset_pre_valid: got %b want 1", bus.redir_valid); end
    #2 rst = 1'b0;
    #1;
    tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL areset_valid: got %b want 0", bus.redir_valid); end
    tests++; if (bus.squash !== 1'b0) begin fails++; $display("FAIL areset_squash: got %b want 0", bus.squash); end
    tests++; if (bus.redir_addr !== 32'h0) begin fails++; $display("FAIL areset_addr: got %h want 0", bus.redir_addr); end
    tests++; if (bus.redir_src !== 2'd0) begin fails++; $display("FAIL areset_src: got %0d want 0", bus.redir_src); end
`ifdef PC_REDIR_CNT_EN
    tests++; if (bus.redir_cnt !== 16'd0) begin fails++; $display("FAIL areset_cnt: got %0d want 0", bus.redir_cnt); end
`endif
    @(negedge clk);
    rst = 1'b1;
    bus.stall = 6'b000000;
    tick();
    tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL areset_idle_valid: got %b want 0", bus.redir_valid); end
    tests++; if (bus.squash !== 1'b0) begin fails++; $display("FAIL areset_idle_squash: got %b want 0", bus.squash); end
    bus.jmp_fl = 1'b1; bus.jmp_addr = 32'h0000_0A00;
    tick();
    clear_reqs();
    tests++; if (bus.redir_addr !== 32'h0000_0A00) begin fails++; $display("FAIL areset_after_addr: got %h want 00000a00", bus.redir_addr); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.stall = 6'b000000;
    clear_reqs();
    #23;
    rst = 1'b1;
    test_reset();
    test_jump();
    test_stall_priority();
    test_same_cycle();
    test_back_to_back();
    test_flush_equal();
    test_kill();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
